// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready handshakes on both sides.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of each frame.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  input  logic             sout_ready,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             xfer_s;
  logic             load_s;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign xfer_s    = valid_q & sout_ready;
  assign din_ready = ~rst & ((state_q == IDLE) | (xfer_s & last_q));
  assign load_s    = din_valid & din_ready;
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign sout_last  = last_q;
  assign busy       = valid_q;

  // State register; outputs are registered copies of the next presented bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      sout_q   <= sout_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic; a load (from IDLE or at the final transfer) overrides the frame exit
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (xfer_s) begin
          if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = advance(shift_q);
          end
        end else begin
          state_d = SHIFT;
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (xfer_s) begin
          state_d = IDLE;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load_s) begin
      state_d  = SHIFT;
      cnt_d    = '0;
      shift_d  = din;
`ifdef PISO_PARITY_EN
      parity_d = ^din;
`endif
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Output logic: derive the bit to present in the next cycle from the next state
  always_comb begin
    sout_d  = 1'b0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    case (state_d)
      SHIFT: begin
        valid_d = 1'b1;
        sout_d  = head_bit(shift_d);
`ifdef PISO_PARITY_EN
        last_d  = 1'b0;
`else
        last_d  = (cnt_d == LAST_IDX);
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        valid_d = 1'b1;
        sout_d  = parity_d;
        last_d  = 1'b1;
      end
`endif
      default: begin
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed bench for piso_serializer (WIDTH=8), checked against a
// queue-of-frame-bits reference model; honours PISO_PARITY_EN when defined.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       sout_ready = 1'b1;
  logic       din_ready, sout, sout_valid, sout_last, busy;

  logic [7:0] din_l = 8'h00;
  logic       din_valid_l = 1'b0;
  logic       sout_ready_l = 1'b1;
  logic       din_ready_l, sout_l, sout_valid_l, sout_last_l, busy_l;

  int vectors = 0;
  int miscompares = 0;

  bit mq[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last),
    .sout_ready(sout_ready), .busy(busy)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din_l), .din_valid(din_valid_l), .din_ready(din_ready_l),
    .sout(sout_l), .sout_valid(sout_valid_l), .sout_last(sout_last_l),
    .sout_ready(sout_ready_l), .busy(busy_l)
  );

  // Bit i of a frame carrying word w: data bits in the chosen order, then parity.
  function automatic bit fbit(input logic [7:0] w, input int i, input bit msb);
    if (i >= 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  // Expected {busy, sout_valid, sout, sout_last, din_ready} for the current inputs.
  function automatic logic [4:0] model_exp();
    bit act;
    bit lst;
    act = (mq.size() > 0);
    lst = (mq.size() == 1);
    return {act, act, act ? mq[0] : 1'b0, lst, !rst && (!act || (sout_ready && lst))};
  endfunction

  // Apply the effect of the coming rising edge to the model.
  function automatic void model_step();
    bit act;
    bit lst;
    bit ld;
    if (rst) begin
      mq.delete();
      return;
    end
    act = (mq.size() > 0);
    lst = (mq.size() == 1);
    ld  = din_valid && (!act || (sout_ready && lst));
    if (act && sout_ready) void'(mq.pop_front());
    if (ld) for (int i = 0; i < FLEN; i++) mq.push_back(fbit(din, i, 1'b1));
  endfunction

  task automatic test_reset();
    logic [4:0] got;
    logic [4:0] got_l;
    din_valid = 1'b1;
    din       = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      got   = {busy, sout_valid, sout, sout_last, din_ready};
      got_l = {busy_l, sout_valid_l, sout_l, sout_last_l, din_ready_l};
      vectors += 2;
      if (got !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_msb cyc %0d got %b want %b", i, got, 5'b00000);
      end
      if (got_l !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_lsb cyc %0d got %b want %b", i, got_l, 5'b00000);
      end
      model_step();
    end
    @(negedge clk);
    rst       = 1'b0;
    din_valid = 1'b0;
    #1;
    got = {busy, sout_valid, sout, sout_last, din_ready};
    vectors++;
    if (got !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_release got %b want %b", got, 5'b00001);
    end
    model_step();
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    logic [4:0] got;
    logic [4:0] want;
    for (int k = 0; k < 4; k++) begin
      w = (k == 0) ? 8'h01 : 8'($urandom);
      for (int i = 0; i <= FLEN; i++) begin
        @(negedge clk);
        din_valid_l = (i == 0);
        din_l       = (i == 0) ? w : 8'($urandom);
        #1;
        if (i == 0) want = 5'b00001;
        else        want = {1'b1, 1'b1, fbit(w, i - 1, 1'b0), i == FLEN, i == FLEN};
        got = {busy_l, sout_valid_l, sout_l, sout_last_l, din_ready_l};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL lsb_first word %h cyc %0d got %b want %b", w, i, got, want);
        end
      end
    end
    @(negedge clk);
    din_valid_l = 1'b0;
  endtask

  task automatic test_single_a5();
    logic [4:0] got;
    logic [4:0] want;
    logic [7:0] obs = 8'h00;
    for (int i = 0; i <= FLEN + 1; i++) begin
      @(negedge clk);
      din_valid  = (i == 0);
      din        = (i == 0) ? 8'hA5 : 8'($urandom);
      sout_ready = 1'b1;
      #1;
      if (i >= 1 && i <= 8) obs = {obs[6:0], sout};
      want = model_exp();
      got  = {busy, sout_valid, sout, sout_last, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL a5_frame cyc %0d got %b want %b", i, got, want);
      end
      model_step();
    end
    vectors++;
    if (obs !== 8'hA5) begin
      miscompares++;
      $display("FAIL a5_bits got %h want %h", obs, 8'hA5);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  got;
    logic [4:0]  want;
    logic [15:0] obs = 16'h0000;
    int          nvalid = 0;
    int          nready = 0;
    for (int i = 0; i <= 2 * FLEN + 1; i++) begin
      @(negedge clk);
      din_valid  = (i <= FLEN);
      din        = (i == 0) ? 8'h3C : 8'hFF;
      sout_ready = 1'b1;
      #1;
      if (sout_valid) begin
        nvalid++;
        if (din_ready) nready++;
        if (!sout_last || FLEN == 8) obs = {obs[14:0], sout};
      end
      want = model_exp();
      got  = {busy, sout_valid, sout, sout_last, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL b2b cyc %0d got %b want %b", i, got, want);
      end
      model_step();
    end
    vectors += 2;
    if (nvalid !== 2 * FLEN) begin
      miscompares++;
      $display("FAIL b2b_valid_cycles got %0d want %0d", nvalid, 2 * FLEN);
    end
    if (nready !== 2) begin
      miscompares++;
      $display("FAIL b2b_ready_boundaries got %0d want %0d", nready, 2);
    end
`ifndef PISO_PARITY_EN
    vectors++;
    if (obs !== 16'h3CFF) begin
      miscompares++;
      $display("FAIL b2b_bits got %h want %h", obs, 16'h3CFF);
    end
`endif
  endtask

  task automatic test_stall();
    logic [4:0] got;
    logic [4:0] want;
    int         nvalid = 0;
    int         nheld = 0;
    for (int i = 0; i <= FLEN + 3; i++) begin
      @(negedge clk);
      din_valid  = (i == 0);
      din        = (i == 0) ? 8'hA5 : 8'($urandom);
      sout_ready = !(i == 3 || i == 4);
      #1;
      if (sout_valid) nvalid++;
      if (i >= 3 && i <= 5 && sout_valid && sout && !din_ready) nheld++;
      want = model_exp();
      got  = {busy, sout_valid, sout, sout_last, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stall cyc %0d got %b want %b", i, got, want);
      end
      model_step();
    end
    vectors += 2;
    if (nvalid !== FLEN + 2) begin
      miscompares++;
      $display("FAIL stall_length got %0d want %0d", nvalid, FLEN + 2);
    end
    if (nheld !== 3) begin
      miscompares++;
      $display("FAIL stall_bit3_held got %0d want %0d", nheld, 3);
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] got;
    logic [4:0] want;
    logic [7:0] obs = 8'h00;
    for (int i = 0; i <= 6 + FLEN; i++) begin
      @(negedge clk);
      rst        = (i == 4);
      din_valid  = (i == 0) || (i == 4) || (i == 5);
      din        = (i == 0) ? 8'hA5 : (i == 5) ? 8'h01 : 8'($urandom);
      sout_ready = 1'b1;
      #1;
      if (i == 5) begin
        vectors++;
        if ({sout_valid, sout, din_ready} !== 3'b001) begin
          miscompares++;
          $display("FAIL abort_state got %b want %b", {sout_valid, sout, din_ready}, 3'b001);
        end
      end
      if (i >= 6 && i <= 13) obs = {obs[6:0], sout};
      want = model_exp();
      got  = {busy, sout_valid, sout, sout_last, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_midframe cyc %0d got %b want %b", i, got, want);
      end
      model_step();
    end
    vectors++;
    if (obs !== 8'h01) begin
      miscompares++;
      $display("FAIL fresh_frame_bits got %h want %h", obs, 8'h01);
    end
  endtask

  task automatic test_random();
    logic [4:0] got;
    logic [4:0] want;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din_valid  = ($urandom_range(0, 1) == 0);
      din        = 8'($urandom);
      sout_ready = ($urandom_range(0, 9) < 7);
      #1;
      want = model_exp();
      got  = {busy, sout_valid, sout, sout_last, din_ready};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random cyc %0d got %b want %b", i, got, want);
      end
      model_step();
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_single_a5();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
